// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with a start/ack handshake.
// It reports terminal count and has an optional periodic auto-reload mode.
// Define COUNTDOWN_TIMER_PAUSE_EN to add a pause input.
// While pause is high in RUN, counting is frozen.
module countdown_timer #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX   = WIDTH'(10)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    input  logic             stop,
    input  logic             ack,
`ifdef COUNTDOWN_TIMER_PAUSE_EN
    input  logic             pause,
`endif
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] loadClamped;
    logic             pauseActive;

    // Out-of-range load values saturate at MAX instead of being truncated.
    assign loadClamped = (load_val > MAX) ? MAX : load_val;

`ifdef COUNTDOWN_TIMER_PAUSE_EN
    assign pauseActive = pause;
`else
    assign pauseActive = 1'b0;
`endif

    // State, count, latched reload value and mode; all are cleared at once by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
        end
    end

    // Next-state logic: stop beats pause, and pause beats reload and DONE.
    // A zero count in RUN is always resolved before the count could wrap.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d    = loadClamped;
                    reload_d = loadClamped;
                    mode_d   = auto_reload;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (!pauseActive) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end else if (mode_q) begin
                        cnt_d = reload_q;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (ack) begin
                    if (start) begin
                        cnt_d    = loadClamped;
                        reload_d = loadClamped;
                        mode_d   = auto_reload;
                        state_d  = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from registered state only.
    // As a result, tc stays one continuous pulse even across a pause.
    assign cnt  = cnt_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign tc   = (state_q == RUN) && (cnt_q == '0);

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable down-counting timer: the counterpart to the team's up-counter (0 to MAX, then wrap). It counts from a loaded value down to 0 and reports terminal count. Start and done use a request/acknowledge handshake, with an optional periodic auto-reload mode. It serves as the basic delay/timeout block for control logic in the same design.

Parameters:
WIDTH, 4, counter width in bits.
MAX, 4'b1010 (10), largest loadable count; load_val above MAX is clamped to MAX.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  reset, asynchronous, active-high; clears all state immediately, independent of clk.
start  input  1  request to load load_val and begin counting; sampled on posedge.
load_val  input  WIDTH  initial count N; sampled only when start is accepted.
auto_reload  input  1  sampled with start; 1 means periodic mode (reload N on reaching 0).
stop  input  1  abort counting; effective in RUN only.
ack  input  1  acknowledges done; effective in DONE only.
cnt  output  WIDTH  current count value (registered).
busy  output  1  high while in RUN.
tc  output  1  terminal-count pulse, high for exactly the cycle in which cnt==0 in RUN.
done  output  1  high in DONE until acknowledged.

Behaviour:
- Reset values: state IDLE, cnt=0, busy=0, tc=0, done=0. Internal reload value and mode bit are 0.
- States: IDLE, RUN, DONE. All outputs are registered or decoded from registered state.
- IDLE, start=1 at edge k:
  - cnt <= min(load_val, MAX); N and auto_reload are latched; state goes to RUN.
  - busy=1 from edge k.
- RUN:
  - While cnt>0: cnt decrements by 1 per edge.
  - Count sequence after edge k: N, N-1, ..., 0. cnt reaches 0 after edge k+N; tc=1 during that cycle.
  - Start-to-tc latency is N edges.
  - N=0: cnt=0 right after edge k, so tc is high in the first RUN cycle.
- On the cnt==0 cycle in RUN:
  - Mode 0: next edge gives state DONE, done=1, busy=0, cnt held at 0.
  - Mode 1: next edge reloads cnt <= N and state stays RUN. Period is N+1 cycles, with tc pulsing once per period.
- stop=1 in RUN: next edge gives state IDLE, cnt=0, busy=0. stop has priority over tc, reload and the DONE transition on the same edge; tc is still high during the cycle it is decoded.
- start while in RUN is ignored (no restart, N unchanged).
- DONE:
  - ack=1: next edge gives state IDLE, done=0.
  - ack=1 and start=1 on the same edge: go directly to RUN with a fresh load (back-to-back restart); done=0, busy=1.
  - start without ack is ignored.
- stop in IDLE or DONE, and ack in IDLE or RUN, are ignored.
- Decrement never wraps: cnt==0 in RUN always resolves via reload, DONE, or stop, never 0 to all-ones.
- rst asserted mid-RUN or in DONE: outputs go to reset values asynchronously, with no tc or done glitch afterwards. On release, the block waits in IDLE for a new start.

Optional Feature:
Macro COUNTDOWN_TIMER_PAUSE_EN.
- Defined: adds input port pause (1 bit). While pause=1 in RUN, cnt holds and no reload or DONE transition occurs. tc stays high if cnt==0 but is treated as one pulse; it does not re-trigger on pause release. stop still has priority over pause. pause in IDLE or DONE has no effect.
- Undefined: port pause is absent and counting is never suspended.

Test Plan:
- Reset mid-count:
  - Stimulus: rst pulse, then start with load_val=3, auto_reload=0; assert rst asynchronously between clock edges while cnt=2.
  - Response: cnt goes 3,2 then immediately 0 on rst; busy=0, done=0, no tc afterwards.
- One-shot count:
  - Stimulus: start, load_val=4, auto_reload=0.
  - Response: cnt 4,3,2,1,0; tc high only on the cnt=0 cycle (4 edges after start); done=1 next cycle; ack gives IDLE one edge later.
- Clamp and zero load:
  - Stimulus: load_val=15 with MAX=10; then separately load_val=0.
  - Response: first case cnt starts at 10, tc at edge 10. Zero-load case tc in the first RUN cycle, then done=1.
- Auto-reload then stop:
  - Stimulus: load_val=2, auto_reload=1, run 9 cycles, then stop.
  - Response: cnt 2,1,0,2,1,0,2,1,0 with tc every 3rd cycle; done never asserted; stop gives IDLE, cnt=0, busy=0.
- Handshake edges:
  - Stimulus: start during RUN; then in DONE assert start alone; then ack with start and load_val=1.
  - Response: start during RUN changes nothing. start alone in DONE is ignored (done stays 1). ack with start restarts: cnt=1, busy=1, done=0.
- Pause (COUNTDOWN_TIMER_PAUSE_EN only):
  - Stimulus: load_val=5, pause held for 3 cycles at cnt=3.
  - Response: cnt holds 3 for 3 cycles, tc arrives 3 cycles later than unpaused (8 edges after start).
